// File: rtl/avg_pool_1d_scheduler_pkg.sv
// Shared definitions for the 1-D average-pooling scheduler and datapath.
// Holds the FSM encoding and the default counter width.
package avg_pool_1d_scheduler_pkg;

  localparam int POOL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } pool_state_e;

  function automatic logic cfg_is_bad(
    input logic [31:0] k,
    input logic [31:0] s,
    input logic [31:0] l
  );
    return (k == 0) || (s == 0) || (s < k) || (k > l);
  endfunction

endpackage

// File: rtl/avg_pool_1d_scheduler.sv
// Control FSM for a 1-D average pool: sequences clear/accumulate/emit
// strobes for an external datapath over a stream of L samples.
module avg_pool_1d_scheduler
  import avg_pool_1d_scheduler_pkg::*;
#(
  parameter int CNT_W = POOL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_kernel,
  input  logic [CNT_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dp_clr,
  output logic             dp_acc_en,
  output logic             dp_emit,
  output logic [CNT_W-1:0] dp_div,
  input  logic             dp_emit_ready,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] win_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  pool_state_e state_q, state_d;

  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] l_q, l_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic accept;
  logic cfg_bad;
  logic win_last;
  logic pos_wrap;
  logic len_last;

  assign in_ready  = (state_q == ST_RUN);
  assign accept    = in_valid && in_ready;
  assign dp_clr    = accept && (pos_q == ZERO);
  assign dp_acc_en = accept && (pos_q < k_q);
  assign dp_emit   = (state_q == ST_EMIT);
  assign dp_div    = k_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign win_cnt   = win_q;

  assign cfg_bad = cfg_is_bad(32'(cfg_kernel),
                              32'(cfg_stride),
                              32'(cfg_len));

  assign win_last = (pos_q == k_q - ONE);
  assign pos_wrap = (pos_q == s_q - ONE);
  assign len_last = (idx_q == l_q - ONE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    l_d     = l_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    win_d   = win_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            win_d   = ZERO;
            k_d     = cfg_kernel;
            s_d     = cfg_stride;
            l_d     = cfg_len;
            idx_d   = ZERO;
            pos_d   = ZERO;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          idx_d = idx_q + ONE;
          pos_d = pos_wrap ? ZERO : pos_q + ONE;
          // A full window wins over end-of-stream; EMIT ends the job.
          if (win_last) begin
            state_d = ST_EMIT;
          end else if (len_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (dp_emit_ready) begin
          win_d = win_q + ONE;
          if (idx_q == l_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      l_q     <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      l_q     <= l_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      win_q   <= win_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/avg_pool_1d_scheduler.md
AVG_POOL_1D_SCHEDULER -- requirements
Module: avg_pool_1d_scheduler

Interface
REQ-001 Parameter CNT_W, default 16: width of length, kernel and stride fields and of all counters.
REQ-002 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port cfg_start, input, 1: one-cycle pulse that latches the cfg_* fields and starts a job.
REQ-005 Port cfg_kernel, input, CNT_W: window size K.
REQ-006 Port cfg_stride, input, CNT_W: stride S.
REQ-007 Port cfg_len, input, CNT_W: input sample count L.
REQ-008 Port in_valid, input, 1: upstream sample available.
REQ-009 Port in_ready, output, 1: scheduler accepts a sample; accept = in_valid && in_ready.
REQ-010 Port dp_clr, output, 1: datapath clears its accumulator before adding the current sample.
REQ-011 Port dp_acc_en, output, 1: datapath adds the current sample.
REQ-012 Port dp_emit, output, 1: datapath outputs accumulator/dp_div.
REQ-013 Port dp_div, output, CNT_W: divisor; always the latched K.
REQ-014 Port dp_emit_ready, input, 1: datapath output accepted; emit completes when dp_emit && dp_emit_ready.
REQ-015 Port busy, output, 1: job in progress.
REQ-016 Port done, output, 1: one-cycle pulse at job end.
REQ-017 Port cfg_err, output, 1: sticky flag for the last rejected configuration.
REQ-018 Port win_cnt, output, CNT_W: windows emitted in the current or last job.

Function
REQ-019 The FSM shall have the states IDLE, RUN and EMIT.
REQ-020 A config is invalid if K==0, S==0, S<K or K>L; an invalid cfg_start in IDLE shall set cfg_err and the FSM shall stay in IDLE.
REQ-021 A valid cfg_start in IDLE shall clear cfg_err and win_cnt, latch K/S/L, zero the sample counter (idx) and the phase counter (pos), and move to RUN on the next cycle.
REQ-022 cfg_start outside IDLE shall be ignored, and the latched config shall be unchanged.
REQ-023 in_ready shall equal (state==RUN), combinationally.
REQ-024 On each accept, dp_acc_en shall be asserted in the same cycle if pos<K, and dp_clr shall be asserted in the same cycle if pos==0; samples with pos>=K shall be consumed and discarded.
REQ-025 pos shall wrap to 0 after S-1; idx shall increment on every accept.
REQ-026 An accept with pos==K-1 shall move the FSM to EMIT; dp_emit shall be asserted from the next cycle and held until dp_emit_ready is sampled high.
REQ-027 On emit completion, win_cnt shall increment and the FSM shall return to RUN, or to IDLE with done if idx==L.
REQ-028 An accept with idx==L-1 and pos!=K-1 shall go to IDLE with done the next cycle; trailing partial windows shall never be emitted.
REQ-029 Emitted window count shall equal floor((L-K)/S)+1.
REQ-030 dp_clr, dp_acc_en and dp_emit shall never be asserted in IDLE; dp_emit shall be asserted only in EMIT.
REQ-031 busy shall be high in RUN and EMIT.

Reset
REQ-032 rst_n low at a clock edge shall force IDLE and clear idx, pos, win_cnt, cfg_err, done and the latched config to 0, including mid-job or mid-emit.
REQ-033 During and immediately after reset, in_ready, dp_clr, dp_acc_en, dp_emit, busy and done shall be 0, and dp_div shall be 0.

Structure
REQ-034 The FSM state enum and the CNT_W default shall live in the shared pool package, for reuse by the pooling datapath.
REQ-035 The block shall be a single module with no sub-modules; the datapath is instantiated by the parent, not by this block.

Verification
REQ-036 K=4, S=4, L=16, in_valid always 1, dp_emit_ready always 1 -> 4 emits, dp_div=4, dp_clr on idx 0/4/8/12, done once, win_cnt=4.
REQ-037 K=2, S=3, L=10 -> dp_acc_en on idx {0,1,3,4,6,7,9}, emits after idx 1/4/7, idx 9 discarded, win_cnt=3.
REQ-038 K=3, S=3, L=9, dp_emit_ready low for 5 cycles at first emit -> dp_emit held 5+ cycles, in_ready=0 throughout, no sample lost.
REQ-039 cfg_start with K=5, L=4, then with S=2, K=3 -> cfg_err=1, busy stays 0 in both cases.
REQ-040 rst_n low for 1 cycle while in EMIT -> IDLE, all outputs 0; a following valid job runs correctly.
REQ-041 cfg_start pulsed mid-job with a different K -> ignored; dp_div and window count unchanged.
